// File: rtl/test_seq_pkg.sv
// Shared types and sizing helpers for the self-test sequencer.
package test_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WD_W = 16;

    // Width of a test index; a single-test bank still gets one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/watchdog_counter.sv
// Per-test cycle counter that saturates at the terminal count instead of wrapping.
module watchdog_counter
    import test_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            enable,
    input  logic [WD_W-1:0] term,
    output logic            expired
);

    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == term);

endmodule

// File: rtl/test_sequencer.sv
// Clocked controller that runs each unit-test block in turn with a watchdog,
// collecting fail/timeout masks and a sequence-complete flag.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter  int N_TESTS = 6,
    parameter  int TIMEOUT = 1000,
    localparam int IW      = idx_w(N_TESTS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    output logic [N_TESTS-1:0] test_start,
    input  logic [N_TESTS-1:0] test_done,
    input  logic [N_TESTS-1:0] test_pass,
    output logic               busy,
    output logic               finish,
    output logic               all_pass,
    output logic [N_TESTS-1:0] fail_mask,
    output logic [N_TESTS-1:0] timeout_mask,
    output logic [IW-1:0]      cur_test
);

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [N_TESTS-1:0] start_q, start_d;
    logic [N_TESTS-1:0] fail_q, fail_d;
    logic [N_TESTS-1:0] tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic               finish_q, finish_d;
    logic               allp_q, allp_d;

    logic done_cur, pass_cur, last_test, wd_expired;

    assign done_cur  = test_done[idx_q];
    assign pass_cur  = test_pass[idx_q];
    assign last_test = (idx_q == IW'(N_TESTS - 1));

    // Counter is held at zero outside RUN, so every test starts from a fresh count.
    watchdog_counter u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != RUN),
        .enable  (state_q == RUN),
        .term    (WD_W'(TIMEOUT - 1)),
        .expired (wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        start_d  = start_q;
        fail_d   = fail_q;
        tmo_d    = tmo_q;
        busy_d   = busy_q;
        finish_d = finish_q;
        allp_d   = allp_q;

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    start_d  = N_TESTS'(1);
                    fail_d   = '0;
                    tmo_d    = '0;
                    busy_d   = 1'b1;
                    finish_d = 1'b0;
                    allp_d   = 1'b0;
                end
            end
            RUN: begin
                if (done_cur || wd_expired) begin
                    // A done arriving on the expiry cycle still counts as a normal completion.
                    if (done_cur)
                        fail_d[idx_q] = ~pass_cur;
                    else
                        tmo_d[idx_q] = 1'b1;
                    start_d = '0;
                    if (last_test) begin
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        finish_d = 1'b1;
                        allp_d   = (fail_d == '0) && (tmo_d == '0);
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                state_d = RUN;
                idx_d   = idx_q + 1'b1;
                start_d = N_TESTS'(1) << idx_d;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            start_q  <= '0;
            fail_q   <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            allp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            start_q  <= start_d;
            fail_q   <= fail_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            allp_q   <= allp_d;
        end
    end

    assign test_start   = start_q;
    assign busy         = busy_q;
    assign finish       = finish_q;
    assign all_pass     = allp_q;
    assign fail_mask    = fail_q;
    assign timeout_mask = tmo_q;
    assign cur_test     = idx_q;

endmodule
